// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-Excess-3 sequencer.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam logic [3:0] EXC3_OFFSET  = 4'd3;
  localparam logic [3:0] EXC3_INVALID = 4'h0;

  function automatic logic is_bcd_invalid(input logic [3:0] d);
    return (d > BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_excess3_digit.sv
// Combinational single-digit BCD to Excess-3 converter with invalid-digit flag.
module bcd_excess3_digit
  import bcd_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [3:0] exc_o,
  output logic       invalid_o
);

  always_comb begin
    invalid_o = is_bcd_invalid(bcd_i);
    exc_o     = invalid_o ? EXC3_INVALID : (bcd_i + EXC3_OFFSET);
  end

endmodule

// File: rtl/bcd_excess3_seq.sv
// Multi-digit BCD to Excess-3 sequencer: one digit per cycle through a single shared converter.
module bcd_excess3_seq
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_exc,
  output logic                  out_err,
  output logic                  busy
);

  localparam int unsigned IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

  state_t                state_q, state_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0]   src_q, src_d;
  logic [4*DIGITS-1:0]   result_q, result_d;
  logic                  err_q, err_d;

  logic [3:0]            cur_digit;
  logic [3:0]            cur_exc;
  logic                  cur_invalid;

  assign cur_digit = src_q[4*idx_q +: 4];

  bcd_excess3_digit u_digit (
    .bcd_i     (cur_digit),
    .exc_o     (cur_exc),
    .invalid_o (cur_invalid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      src_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      src_q    <= src_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    src_d    = src_q;
    result_d = result_q;
    err_d    = err_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          src_d   = in_bcd;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = CONV;
        end
      end
      CONV: begin
        result_d[4*idx_q +: 4] = cur_exc;
        err_d                  = err_q | cur_invalid;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Result registers are only written in CONV, so they hold stable throughout DONE.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_exc   = result_q;
  assign out_err   = err_q;

endmodule
